// File: rtl/rr_enc_arbiter_pkg.sv
// rr_enc_arbiter_pkg: shared state encodings, default parameters and rotate helper
package rr_enc_arbiter_pkg;
    localparam int N_DEF        = 8;
    localparam int IDXW_DEF     = 3;
    localparam int MAX_HOLD_DEF = 16;
    localparam int HCW_DEF      = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [7:0] rotr8(input logic [7:0] v, input logic [2:0] s);
        logic [15:0] d;
        d = {v, v} >> s;
        return d[7:0];
    endfunction
endpackage

// File: rtl/rr_enc_arbiter_if.sv
// rr_enc_arbiter_if: request/grant bundle between requesters and the arbiter
interface rr_enc_arbiter_if #(
    parameter int N    = 8,
    parameter int IDXW = 3
);
    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;
    logic            timeout;

    modport master (output req, done, input gnt, gnt_idx, gnt_valid, timeout);
    modport slave  (input req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_enc_arbiter_prio_enc8.sv
// prio_enc8: combinational 8-to-3 priority encoder, lowest set bit wins
module prio_enc8 (
    input  logic [7:0] in,
    output logic [2:0] idx,
    output logic       valid
);
    always_comb begin
        idx = '0;
        for (int i = 7; i >= 0; i--)
            if (in[i]) idx = 3'(i);
    end

    assign valid = |in;
endmodule

// File: rtl/rr_enc_arbiter.sv
// rr_enc_arbiter: 8-way round-robin arbiter with hold limit and one-hot/binary grant
module rr_enc_arbiter
    import rr_enc_arbiter_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IDXW     = IDXW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HCW      = HCW_DEF
) (
    input logic             clk,
    input logic             rst_n,
    rr_enc_arbiter_if.slave bus
);
    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [HCW-1:0]  hold_cnt;
    logic [2:0]      enc_idx;
    logic            enc_valid;
    logic [IDXW-1:0] win;
    logic            rel_a, rel_b, rel_c;

    // search starts at ptr: rotate so ptr lands on bit 0, then undo the rotation
    prio_enc8 u_enc (
        .in    (rotr8(bus.req, ptr)),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign win   = ptr + enc_idx;
    assign rel_a = bus.done;
    assign rel_b = !bus.req[bus.gnt_idx];
    assign rel_c = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            hold_cnt      <= '0;
            bus.gnt       <= '0;
            bus.gnt_idx   <= '0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                ST_IDLE: if (enc_valid) begin
                    state         <= ST_GRANT;
                    bus.gnt       <= N'(1) << win;
                    bus.gnt_idx   <= win;
                    bus.gnt_valid <= 1'b1;
                    hold_cnt      <= '0;
                end
                ST_GRANT: if (rel_a || rel_b || rel_c) begin
                    state         <= ST_GAP;
                    bus.gnt       <= '0;
                    bus.gnt_idx   <= '0;
                    bus.gnt_valid <= 1'b0;
                    ptr           <= bus.gnt_idx + 1'b1;
                    bus.timeout   <= rel_c && !rel_a && !rel_b;
                end else begin
                    hold_cnt <= (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
                end
                ST_GAP: state <= ST_IDLE;
                default: begin
                    state         <= ST_IDLE;
                    bus.gnt       <= '0;
                    bus.gnt_idx   <= '0;
                    bus.gnt_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_enc_arbiter.sv
// tb_rr_enc_arbiter: directed tables, corner sequences and random run against a reference model
module tb_rr_enc_arbiter;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    rr_enc_arbiter_if #(.N(8), .IDXW(3)) bus ();

    rr_enc_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(MH), .HCW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [2:0] idx;
        logic       v;
        logic       to;
    } vec_t;

    vec_t tbl[24];

    int m_owner, m_held, m_gap, m_ptr;
    bit m_to;

    task automatic m_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_ptr   = 0;
        m_to    = 0;
    endtask

    task automatic m_step();
        bit a, b, c;
        m_to = 0;
        if (m_owner >= 0) begin
            a = bus.done;
            b = !bus.req[m_owner];
            c = (MH != 0) && (m_held == MH - 1);
            if (a || b || c) begin
                m_to    = c && !a && !b;
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_gap   = 1;
            end else m_held++;
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else begin
            for (int k = 0; k < 8; k++)
                if (m_owner < 0 && bus.req[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_held  = 0;
                end
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] g, input logic [2:0] i, input logic v, input logic t);
        tests++;
        if (bus.gnt !== g || bus.gnt_idx !== i || bus.gnt_valid !== v || bus.timeout !== t) begin
            fails++;
            $display("FAIL %s @%0t: got gnt=%h idx=%0d v=%b to=%b, expected gnt=%h idx=%0d v=%b to=%b",
                     nm, $time, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, g, i, v, t);
        end
    endtask

    task automatic chk_model(input string nm);
        chk(nm, m_owner >= 0 ? 8'(1 << m_owner) : 8'h00, m_owner >= 0 ? 3'(m_owner) : 3'd0,
            m_owner >= 0, m_to);
    endtask

    task automatic cyc(input bit use_model, input string nm);
        @(posedge clk);
        m_step();
        #1;
        if (use_model) chk_model(nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        #1 chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{8'h18, 1'b0, 3'd3, 1'b1, 1'b0};
        tbl[1]  = '{8'h18, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{8'h18, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{8'h18, 1'b0, 3'd4, 1'b1, 1'b0};
        tbl[4]  = '{8'h18, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{8'h20, 1'b0, 3'd5, 1'b1, 1'b0};
        tbl[8]  = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[9]  = '{8'h41, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{8'h41, 1'b0, 3'd6, 1'b1, 1'b0};
        tbl[11] = '{8'h41, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[12] = '{8'h02, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{8'h02, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[14] = '{8'h02, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[15] = '{8'h02, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[16] = '{8'h02, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[17] = '{8'h02, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[18] = '{8'h02, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[19] = '{8'h02, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[20] = '{8'h02, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[21] = '{8'h02, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[22] = '{8'h02, 1'b0, 3'd1, 1'b1, 1'b0};
        tbl[23] = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};

        m_reset();
        bus.req  = 8'hFF;
        bus.done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 chk("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 24; k++) begin
            bus.req  = tbl[k].req;
            bus.done = tbl[k].done;
            cyc(1'b0, "");
            chk($sformatf("tbl[%0d]", k), tbl[k].v ? 8'(1 << tbl[k].idx) : 8'h00, tbl[k].idx, tbl[k].v, tbl[k].to);
        end

        do_reset();
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            bus.done = 1'b0;
            cyc(1'b0, "");
            chk($sformatf("rr_grant%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b0);
            bus.done = 1'b1;
            cyc(1'b0, "");
            chk("rr_gap", 8'h00, 3'd0, 1'b0, 1'b0);
            bus.done = 1'b0;
            cyc(1'b0, "");
            chk("rr_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        end

        do_reset();
        bus.req  = 8'h10;
        bus.done = 1'b0;
        cyc(1'b1, "pre_async");
        #2 rst_n = 1'b0;
        m_reset();
        #1 chk("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 8'h81;
        cyc(1'b1, "post_rst_model");
        chk("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

        for (int k = 0; k < 800; k++) begin
            #1;
            if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
            else if ($urandom_range(0, 9) == 0) bus.req = 8'(1 << $urandom_range(0, 7));
            bus.done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 249) == 0) do_reset();
            cyc(1'b1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
